// File: rtl/mole_spawner_pkg.sv
// rtl/mole_spawner_pkg.sv - shared state encodings and defaults for the whack-a-mole blocks
// Build option: NO_REPEAT_EN (consumed by mole_spawner).
package mole_spawner_pkg;

    localparam int N_MOLES_DEF = 7;
    localparam int IDX_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_COOL = 2'd2
    } state_t;

endpackage

// File: rtl/mole_tick_timer.sv
// rtl/mole_tick_timer.sv - loadable tick-driven down-timer
// expire is combinational; the count never wraps below 1.
module mole_tick_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q > TMR_W'(1))) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = tick && (cnt_q == TMR_W'(1));

endmodule

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - picks, shows and times out one mole, judges presses, then cools down
// Build option: NO_REPEAT_EN avoids raising the same mole twice in a row.
module mole_spawner
    import mole_spawner_pkg::*;
#(
    parameter int N_MOLES    = N_MOLES_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int TMR_W      = 8,
    parameter int UP_TICKS   = 20,
    parameter int COOL_TICKS = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               tick,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [N_MOLES-1:0] i_btn,
    output logic [N_MOLES-1:0] o_mole,
    output logic               o_hit,
    output logic               o_miss,
    output logic               o_busy
);

    localparam logic [TMR_W-1:0]   UP_VAL   = TMR_W'(UP_TICKS);
    localparam logic [TMR_W-1:0]   COOL_VAL = TMR_W'(COOL_TICKS);
    localparam logic [N_MOLES-1:0] ONE_HOT0 = N_MOLES'(1);

    state_t             state_q, state_d;
    logic [N_MOLES-1:0] mole_q, mole_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [IDX_W-1:0]   sel_raw, sel;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expire;
    logic               judged;

`ifdef NO_REPEAT_EN
    logic [IDX_W-1:0]   last_q, last_d;

    always_comb begin
        sel_raw = (i_idx >= IDX_W'(N_MOLES)) ? '0 : i_idx;
        sel     = sel_raw;
        if (sel_raw == last_q) begin
            sel = (sel_raw == IDX_W'(N_MOLES - 1)) ? '0 : sel_raw + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        sel_raw = (i_idx >= IDX_W'(N_MOLES)) ? '0 : i_idx;
        sel     = sel_raw;
    end
`endif

    mole_tick_timer #(.TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .expire   (tmr_expire)
    );

    // In UP the raised mole is held one-hot in mole_q, so it doubles as the button mask.
    always_comb begin
        state_d  = state_q;
        mole_d   = mole_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = UP_VAL;
        judged   = 1'b0;
`ifdef NO_REPEAT_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    mole_d   = ONE_HOT0 << sel;
                    tmr_load = 1'b1;
                    state_d  = ST_UP;
`ifdef NO_REPEAT_EN
                    last_d   = sel;
`endif
                end
            end
            ST_UP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    mole_d  = '0;
                end else if (|(i_btn & mole_q)) begin
                    hit_d  = 1'b1;
                    judged = 1'b1;
                end else if ((|i_btn) || tmr_expire) begin
                    miss_d = 1'b1;
                    judged = 1'b1;
                end
                if (judged) begin
                    mole_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = COOL_VAL;
                    state_d  = (COOL_TICKS == 0) ? ST_IDLE : ST_COOL;
                end
            end
            ST_COOL: begin
                if (!en || tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mole_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            mole_q  <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mole_q  <= mole_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign o_mole = mole_q;
    assign o_hit  = hit_q;
    assign o_miss = miss_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule
